keypad_scan_decoder: RTL and testbench

- Sits directly downstream of the 2-bit scan counter (`contador`) in the 4×4 keypad path.
- Turns the counter's column index into active-low column drive and gates the counter's `en` via `scan_en`, so scanning freezes on a press.
- Synchronises and debounces the row inputs, then emits one `key_valid` pulse with a 4-bit key code per debounced press.

---
 rtl/keypad_defs.sv | 33 +++
 rtl/contador.sv | 26 ++
 rtl/sync_2ff.sv | 39 +++
 rtl/keypad_scan_decoder.sv | 149 ++++++++++++++
 tb/tb_keypad_scan_decoder.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/keypad_defs.sv
// -----------------------------------------------------------------------------
// keypad_defs
// Shared definitions for the 4x4 keypad scan path: FSM state encoding, idle row
// pattern, key-code width and the row priority encoder.
// -----------------------------------------------------------------------------
package keypad_defs;

    localparam int         KEY_W     = 4;
    localparam logic [3:0] ROWS_IDLE = 4'hF;

    localparam logic [1:0] ENC_SCAN       = 2'd0;
    localparam logic [1:0] ENC_PRESS_DB   = 2'd1;
    localparam logic [1:0] ENC_PRESSED    = 2'd2;
    localparam logic [1:0] ENC_RELEASE_DB = 2'd3;

    typedef enum logic [1:0] {
        ST_SCAN       = ENC_SCAN,
        ST_PRESS_DB   = ENC_PRESS_DB,
        ST_PRESSED    = ENC_PRESSED,
        ST_RELEASE_DB = ENC_RELEASE_DB
    } state_t;

    // Index of the lowest active (low) row; 0 when no row is active.
    function automatic logic [1:0] lowest_active(input logic [3:0] rows_n);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!rows_n[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/contador.sv
// -----------------------------------------------------------------------------
// contador
// 2-bit column scan counter; advances by one on each cycle en is high and
// wraps 3 -> 0.
//   clk   : system clock
//   reset : asynchronous active-low reset
//   en    : advance strobe
//   q     : current column index
// -----------------------------------------------------------------------------
module contador (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    output logic [1:0] q
);

    logic [1:0] r_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)  r_q <= 2'd0;
        else if (en) r_q <= r_q + 2'd1;
    end

    assign q = r_q;

endmodule

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchroniser for asynchronous inputs. Resets to all ones so that
// active-low inputs read as inactive out of reset.
//   clk         : system clock
//   reset       : asynchronous active-low reset
//   i_d         : asynchronous input bus
//   o_q         : synchronised output (second stage)
//   o_q_stage1  : first-stage value, i.e. what o_q will show next cycle
// -----------------------------------------------------------------------------
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q,
    output logic [WIDTH-1:0] o_q_stage1
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // NOTE: non-blocking assignments make both stages sample their old inputs
    // on the same edge, giving a true two-stage shift rather than a wire.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_meta <= '1;
            r_sync <= '1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q        = r_sync;
    assign o_q_stage1 = r_meta;

endmodule

// File: rtl/keypad_scan_decoder.sv
// -----------------------------------------------------------------------------
// keypad_scan_decoder
// Drives the active-low keypad columns from the scan counter, synchronises and
// debounces the rows, and emits one key_valid strobe per accepted press.
//   clk       : system clock
//   reset     : asynchronous active-low reset
//   col_idx   : current column from contador.q
//   rows      : raw active-low rows (asynchronous)
//   cols      : active-low one-hot column drive (combinational)
//   scan_en   : advance pulse to contador.en
//   key_code  : {row_idx, col_idx} of the last accepted key
//   key_valid : one-cycle strobe when key_code updates
//   key_held  : high while the accepted key is still pressed
// -----------------------------------------------------------------------------
module keypad_scan_decoder
    import keypad_defs::*;
#(
    parameter int SETTLE_CYCLES   = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       col_idx,
    input  logic [3:0]       rows,
    output logic [3:0]       cols,
    output logic             scan_en,
    output logic [KEY_W-1:0] key_code,
    output logic             key_valid,
    output logic             key_held
);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_PRE  = CNT_W'(SETTLE_CYCLES - 2);
    localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       w_rows_s;
    logic [3:0]       w_rows_s1;
    logic             w_row_hit;
    logic             w_hit_next;
    logic [1:0]       w_row_idx;
    logic             w_cand_active;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [KEY_W-1:0] r_cand;
    logic [KEY_W-1:0] r_key_code;
    logic             r_key_valid;
    logic             r_key_held;
    logic             r_scan_en;

    sync_2ff #(.WIDTH(4)) u_row_sync (
        .clk        (clk),
        .reset      (reset),
        .i_d        (rows),
        .o_q        (w_rows_s),
        .o_q_stage1 (w_rows_s1)
    );

    assign cols          = ~(4'b0001 << col_idx);
    assign w_row_hit     = (w_rows_s != ROWS_IDLE);
    assign w_hit_next    = (w_rows_s1 != ROWS_IDLE);
    assign w_row_idx     = lowest_active(w_rows_s);
    assign w_cand_active = ~w_rows_s[r_cand[3:2]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_SCAN;
            r_cnt       <= '0;
            r_cand      <= '0;
            r_key_code  <= '0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
            r_scan_en   <= 1'b0;
        end else begin
            // NOTE: pulse outputs get a default every cycle so each branch only
            // names the cycles that raise them; nothing holds a stale value.
            r_key_valid <= 1'b0;
            r_scan_en   <= 1'b0;

            case (r_state)
                ST_SCAN: begin
                    if (r_cnt == SETTLE_LAST) begin
                        r_cnt <= '0;
                        if (w_row_hit) begin
                            r_cand  <= {w_row_idx, col_idx};
                            r_state <= ST_PRESS_DB;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        // scan_en is registered yet must be high in the sampling
                        // cycle itself, so decide one cycle early from the first
                        // sync stage, which is exactly what rows_s will hold then.
                        if (r_cnt == SETTLE_PRE) r_scan_en <= ~w_hit_next;
                    end
                end

                ST_PRESS_DB: begin
                    if (w_row_hit && (w_row_idx == r_cand[3:2])) begin
                        if (r_cnt == DEB_LAST) begin
                            r_cnt       <= '0;
                            r_key_code  <= r_cand;
                            r_key_valid <= 1'b1;
                            r_key_held  <= 1'b1;
                            r_state     <= ST_PRESSED;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end else begin
                        r_cnt   <= '0;
                        r_state <= ST_SCAN;
                    end
                end

                // Only the accepted row is tracked; other keys are ignored.
                ST_PRESSED: begin
                    if (!w_cand_active) begin
                        r_cnt   <= '0;
                        r_state <= ST_RELEASE_DB;
                    end
                end

                ST_RELEASE_DB: begin
                    if (w_cand_active) begin
                        r_cnt   <= '0;
                        r_state <= ST_PRESSED;
                    end else if (r_cnt == DEB_LAST) begin
                        r_cnt      <= '0;
                        r_key_held <= 1'b0;
                        r_state    <= ST_SCAN;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                default: begin
                    r_cnt   <= '0;
                    r_state <= ST_SCAN;
                end
            endcase
        end
    end

    assign scan_en   = r_scan_en;
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_held  = r_key_held;

endmodule

// File: tb/tb_keypad_scan_decoder.sv
// -----------------------------------------------------------------------------
// tb_keypad_scan_decoder
// Directed bench: keypad_scan_decoder driving a real contador, with a 4x4 key
// matrix model that pulls a row low when its pressed key's column is driven.
// -----------------------------------------------------------------------------
module tb_keypad_scan_decoder;

    logic       clk;
    logic       reset;
    logic [1:0] col_idx;
    logic [3:0] rows;
    logic [3:0] cols;
    logic       scan_en;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    // keys[r*4+c] = 1 means the key at row r, column c is pressed.
    logic [15:0] keys;

    int n_pass  = 0;
    int n_total = 0;
    int n_valid = 0;
    int n_scan  = 0;
    int n_both  = 0;
    int v0, s0, lows;
    logic [3:0] col_seq [4];

    keypad_scan_decoder #(
        .SETTLE_CYCLES   (4),
        .DEBOUNCE_CYCLES (8),
        .CNT_W           (20)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .col_idx   (col_idx),
        .rows      (rows),
        .cols      (cols),
        .scan_en   (scan_en),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    contador u_contador (
        .clk   (clk),
        .reset (reset),
        .en    (scan_en),
        .q     (col_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        rows = 4'hF;
        for (int r = 0; r < 4; r++) rows[r] = ~|(keys[r*4 +: 4] & ~cols);
    end

    // Pulse counters, sampled shortly after each rising edge.
    always @(posedge clk) begin
        #2;
        if (key_valid === 1'b1) n_valid++;
        if (scan_en === 1'b1) n_scan++;
        if (key_valid === 1'b1 && scan_en === 1'b1) n_both++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_scan_on(input logic [3:0] c, input string tag);
        logic found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            @(negedge clk);
            if (scan_en === 1'b1 && cols === c) found = 1'b1;
        end
        check(tag, 32'(found), 32'd1);
    endtask

    task automatic wait_valid(input string tag);
        logic found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            @(negedge clk);
            if (key_valid === 1'b1) found = 1'b1;
        end
        check(tag, 32'(found), 32'd1);
    endtask

    task automatic wait_held_low(input string tag);
        logic found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (key_held === 1'b0) found = 1'b1;
        end
        check(tag, 32'(found), 32'd1);
    endtask

    initial begin
        col_seq = '{4'hE, 4'hD, 4'hB, 4'h7};
        keys    = '0;
        reset   = 1'b0;
        step(3);

        // Reset values
        check("rst_cols", 32'(cols), 32'hE);
        check("rst_scan_en", 32'(scan_en), 32'd0);
        check("rst_key_valid", 32'(key_valid), 32'd0);
        check("rst_key_held", 32'(key_held), 32'd0);
        check("rst_key_code", 32'(key_code), 32'h0);

        // 1: idle scanning, 4-cycle dwell per column
        reset = 1'b1;
        s0 = n_scan;
        for (int k = 1; k <= 40; k++) begin
            step(1);
            if (k % 4 == 2) check("s1_cols", 32'(cols), 32'(col_seq[(k / 4) % 4]));
        end
        check("s1_scan_pulses", 32'(n_scan - s0), 32'd10);
        check("s1_no_valid", 32'(n_valid), 32'd0);

        // 2: row 2 held on column 1
        wait_scan_on(4'hE, "s2_find_col0");
        keys[2*4+1] = 1'b1;
        v0 = n_valid;
        s0 = n_scan;
        step(30);
        check("s2_one_strobe", 32'(n_valid - v0), 32'd1);
        check("s2_key_code", 32'(key_code), 32'h9);
        check("s2_key_held", 32'(key_held), 32'd1);
        check("s2_scan_frozen", 32'(n_scan - s0), 32'd0);
        check("s2_cols_frozen", 32'(cols), 32'hD);

        // 4: release bounce while PRESSED
        lows = 0;
        v0 = n_valid;
        keys[2*4+1] = 1'b0;
        for (int i = 0; i < 4; i++) begin step(1); if (key_held !== 1'b1) lows++; end
        keys[2*4+1] = 1'b1;
        for (int i = 0; i < 2; i++) begin step(1); if (key_held !== 1'b1) lows++; end
        keys[2*4+1] = 1'b0;
        for (int i = 0; i < 10; i++) begin step(1); if (key_held !== 1'b1) lows++; end
        check("s4_held_through_bounce", 32'(lows), 32'd0);
        wait_held_low("s4_held_drops");
        wait_scan_on(4'hD, "s4_scan_resumes");
        check("s4_no_second_strobe", 32'(n_valid - v0), 32'd0);
        check("s4_code_kept", 32'(key_code), 32'h9);

        // 3: short press (bounce) aborts debounce
        wait_scan_on(4'hE, "s3_find_col0");
        v0 = n_valid;
        keys[2*4+1] = 1'b1;
        step(3);
        keys[2*4+1] = 1'b0;
        wait_scan_on(4'hD, "s3_scan_resumes");
        check("s3_no_strobe", 32'(n_valid - v0), 32'd0);
        check("s3_not_held", 32'(key_held), 32'd0);
        check("s3_code_kept", 32'(key_code), 32'h9);

        // 5: rows 1 and 3 together on column 3, lowest wins
        wait_scan_on(4'hB, "s5_find_col2");
        v0 = n_valid;
        keys[1*4+3] = 1'b1;
        keys[3*4+3] = 1'b1;
        step(20);
        check("s5_one_strobe", 32'(n_valid - v0), 32'd1);
        check("s5_key_code", 32'(key_code), 32'h7);
        check("s5_key_held", 32'(key_held), 32'd1);

        // Second key (row 0) while PRESSED is ignored
        keys[0*4+3] = 1'b1;
        step(20);
        check("s5_second_ignored", 32'(n_valid - v0), 32'd1);
        check("s5_code_unchanged", 32'(key_code), 32'h7);
        // Releasing the tracked row lets the remaining key be accepted afresh
        keys[1*4+3] = 1'b0;
        keys[3*4+3] = 1'b0;
        wait_valid("s5_new_strobe");
        check("s5_new_code", 32'(key_code), 32'h3);
        check("s5_new_held", 32'(key_held), 32'd1);
        keys[0*4+3] = 1'b0;
        wait_held_low("s5_release");

        // 6: reset in the middle of PRESS_DB (cnt = 5)
        wait_scan_on(4'h7, "s6_find_col3");
        keys[1*4+0] = 1'b1;
        v0 = n_valid;
        step(10);
        reset = 1'b0;
        #1;
        check("s6_rst_key_held", 32'(key_held), 32'd0);
        check("s6_rst_key_valid", 32'(key_valid), 32'd0);
        check("s6_rst_scan_en", 32'(scan_en), 32'd0);
        check("s6_rst_key_code", 32'(key_code), 32'h0);
        check("s6_rst_cols", 32'(cols), 32'hE);
        step(1);
        keys  = '0;
        reset = 1'b1;
        s0 = n_scan;
        step(16);
        check("s6_scan_pulses", 32'(n_scan - s0), 32'd4);
        check("s6_no_strobe", 32'(n_valid - v0), 32'd0);

        check("valid_scan_overlap", 32'(n_both), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
